// File: rtl/ats21_pkg.sv
// Shared ATS21 client-port definitions: opcodes, response codes, status
// encodings, FSM states and default bus timeouts.
package ats21_pkg;

    localparam int ATS21_CTRL_W        = 16;
    localparam int ATS21_NUM_ALARMS    = 24;
    localparam int ATS21_READY_TIMEOUT = 16;
    localparam int ATS21_STAT_TIMEOUT  = 32;

    typedef enum logic [2:0] {
        OP_SET_CLK = 3'b001,
        OP_EN_CLK  = 3'b010,
        OP_MODE    = 3'b011,
        OP_SET_ALM = 3'b101,
        OP_SET_TMR = 3'b110,
        OP_EN_ALM  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        RSP_ACK      = 2'b00,
        RSP_NACK     = 2'b01,
        RSP_READY_TO = 2'b10,
        RSP_STAT_TO  = 2'b11
    } rsp_code_e;

    localparam logic [1:0] STAT_NONE = 2'b00;
    localparam logic [1:0] STAT_ACK  = 2'b01;
    localparam logic [1:0] STAT_NACK = 2'b10;
    localparam logic [1:0] STAT_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_e;

    // Opcodes 000 and 100 have no bus meaning; they are refused locally.
    function automatic logic is_local_reject(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b100);
    endfunction

endpackage

// File: rtl/ats21_alarm_capture.sv
// Rising-edge capture of ATS21 alarm/timer pulses into sticky pending bits
// with write-1-to-clear and a summary interrupt.
module ats21_alarm_capture
    import ats21_pkg::*;
#(
    parameter int NUM_ALARMS = ATS21_NUM_ALARMS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ALARMS-1:0] alarm_data,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_pend,
    output logic                  alarm_irq
);

    logic [NUM_ALARMS-1:0] data_q, data_d;
    logic [NUM_ALARMS-1:0] pend_q, pend_d;

    // Set is OR-ed in after the clear so a coincident new edge wins.
    always_comb begin
        data_d = alarm_data;
        pend_d = (pend_q & ~alarm_clr) | (alarm_data & ~data_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            pend_q <= '0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign alarm_pend = pend_q;
    assign alarm_irq  = |pend_q;

endmodule

// File: rtl/ats21_client_port.sv
// ATS21 initiator for one client port: sends a 32-bit instruction as two
// ctrl half-words, collects the status and reports a response code.
module ats21_client_port
    import ats21_pkg::*;
#(
    parameter int CTRL_W        = ATS21_CTRL_W,
    parameter int NUM_ALARMS    = ATS21_NUM_ALARMS,
    parameter int READY_TIMEOUT = ATS21_READY_TIMEOUT,
    parameter int STAT_TIMEOUT  = ATS21_STAT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    // Command handshake: an instruction transfers on a cycle where
    // cmd_valid && cmd_ready; cmd_ready is high only in IDLE, so upstream
    // holds cmd_valid and cmd_inst stable until it sees cmd_ready.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_inst,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_code,
    output logic                  busy,
    output logic                  req,
    output logic [CTRL_W-1:0]     ctrl,
    input  logic                  ready,
    input  logic [1:0]            stat,
    input  logic [NUM_ALARMS-1:0] alarm_data,
    output logic [NUM_ALARMS-1:0] alarm_pend,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic                  alarm_irq,
    output state_e                dbg_state
);

    localparam int MAX_TO = (READY_TIMEOUT > STAT_TIMEOUT) ? READY_TIMEOUT : STAT_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO + 1);

    state_e              state_q, state_d;
    logic [31:0]         inst_q, inst_d;
    logic [CNT_W-1:0]    ready_cnt_q, ready_cnt_d;
    logic [CNT_W-1:0]    stat_cnt_q, stat_cnt_d;
    logic                req_q, req_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_code_q, rsp_code_d;

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        ready_cnt_d = ready_cnt_q;
        stat_cnt_d  = stat_cnt_q;
        rsp_code_d  = rsp_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    inst_d = cmd_inst;
                    if (is_local_reject(cmd_inst[31:29])) begin
                        state_d    = S_DONE;
                        rsp_code_d = RSP_NACK;
                    end else begin
                        state_d     = S_REQ;
                        ready_cnt_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (ready) begin
                    state_d = S_HI;
                end else begin
                    ready_cnt_d = ready_cnt_q + CNT_W'(1);
                    if (ready_cnt_d == CNT_W'(READY_TIMEOUT)) begin
                        state_d    = S_DONE;
                        rsp_code_d = RSP_READY_TO;
                    end
                end
            end
            S_HI: state_d = S_LO;
            S_LO: begin
                // A mode write is fire-and-forget on the bus.
                if (inst_q[31:29] == OP_MODE) begin
                    state_d    = S_DONE;
                    rsp_code_d = RSP_ACK;
                end else begin
                    state_d    = S_WAIT;
                    stat_cnt_d = '0;
                end
            end
            S_WAIT: begin
                case (stat)
                    STAT_ACK: begin
                        state_d    = S_DONE;
                        rsp_code_d = RSP_ACK;
                    end
                    STAT_NACK, STAT_RSVD: begin
                        state_d    = S_DONE;
                        rsp_code_d = RSP_NACK;
                    end
                    default: begin
                        stat_cnt_d = stat_cnt_q + CNT_W'(1);
                        if (stat_cnt_d == CNT_W'(STAT_TIMEOUT)) begin
                            state_d    = S_DONE;
                            rsp_code_d = RSP_STAT_TO;
                        end
                    end
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so they follow the state being entered.
        req_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_DONE);
        ctrl_d      = '0;
        if (state_d == S_HI) begin
            ctrl_d = CTRL_W'(inst_d[31:16]);
        end else if (state_d == S_LO) begin
            ctrl_d = CTRL_W'(inst_d[15:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            inst_q      <= '0;
            ready_cnt_q <= '0;
            stat_cnt_q  <= '0;
            req_q       <= 1'b0;
            ctrl_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            ready_cnt_q <= ready_cnt_d;
            stat_cnt_q  <= stat_cnt_d;
            req_q       <= req_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign req       = req_q;
    assign ctrl      = ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign dbg_state = state_q;

    ats21_alarm_capture #(
        .NUM_ALARMS (NUM_ALARMS)
    ) u_alarm (
        .clk        (clk),
        .reset      (reset),
        .alarm_data (alarm_data),
        .alarm_clr  (alarm_clr),
        .alarm_pend (alarm_pend),
        .alarm_irq  (alarm_irq)
    );

endmodule

// File: tb/tb_ats21_client_port.sv
// Bench for ats21_client_port: cycle-accurate bus model per command, response
// scoreboard, alarm capture model and mid-transaction reset.
module tb_ats21_client_port;
    import ats21_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_inst;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        busy, req, ready;
    logic [15:0] ctrl;
    logic [1:0]  stat;
    logic [23:0] alarm_data, alarm_pend, alarm_clr;
    logic        alarm_irq;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  exp_q[$];
    logic [23:0] pend_m, data_prev;

    ats21_client_port #(
        .CTRL_W(16), .NUM_ALARMS(24), .READY_TIMEOUT(16), .STAT_TIMEOUT(32)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .busy(busy),
        .req(req), .ctrl(ctrl), .ready(ready), .stat(stat),
        .alarm_data(alarm_data), .alarm_pend(alarm_pend), .alarm_clr(alarm_clr),
        .alarm_irq(alarm_irq), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) check_val("rsp_extra", 32'(rsp_valid), 32'(0));
            else                   check_val("rsp_code", 32'(rsp_code), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; ready = 1'b0; stat = 2'b00;
        alarm_data = '0; alarm_clr = '0;
        pend_m = '0; data_prev = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req", 32'(req), 32'(0));
        check_val("rst_ctrl", 32'(ctrl), 32'(0));
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_val("rst_rsp_code", 32'(rsp_code), 32'(0));
        check_val("rst_pend", 32'(alarm_pend), 32'(0));
        check_val("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // rw: ready-low cycles before ready (>=16 never); sv/sw: stat value and
    // WAIT cycle index it appears in (sw>=32 never); early: stat before WAIT.
    task automatic run_cmd(input logic [31:0] inst, input int rw, input logic [1:0] sv,
                           input int sw, input logic [1:0] early);
        logic [2:0]  op;
        logic        rej, rto, mode;
        int          r, d, ws;
        logic [1:0]  code;
        state_e      es;
        logic [15:0] ec;
        op   = inst[31:29];
        rej  = (op == 3'b000) || (op == 3'b100);
        rto  = !rej && (rw >= 16);
        mode = (op == 3'b011);
        r    = rej ? 0 : (rto ? 16 : rw + 1);
        ws   = r + 3;
        if (rej)                          begin d = 1;           code = 2'b01; end
        else if (rto)                     begin d = 17;          code = 2'b10; end
        else if (mode)                    begin d = r + 3;       code = 2'b00; end
        else if (sw >= 32 || sv == 2'b00) begin d = ws + 32;     code = 2'b11; end
        else begin d = ws + sw + 1; code = (sv == 2'b01) ? 2'b00 : 2'b01; end

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_inst = inst; ready = 1'b0; stat = early;
        exp_q.push_back(code);
        @(negedge clk);
        check_val("cmd_ready_idle", 32'(cmd_ready), 32'(1));
        for (int k = 1; k <= d + 1; k++) begin
            @(posedge clk); #1;
            // Junk commands while busy must be ignored.
            cmd_valid = (k <= d);
            cmd_inst  = $urandom();
            ready     = !rej && !rto && (k == r);
            if (rej || rto || mode || k < ws) stat = early;
            else if (sw < 32 && (k - ws) == sw) stat = sv;
            else stat = 2'b00;
            @(negedge clk);
            if (k > d)           es = S_IDLE;
            else if (k == d)     es = S_DONE;
            else if (k <= r)     es = S_REQ;
            else if (k == r + 1) es = S_HI;
            else if (k == r + 2) es = S_LO;
            else                 es = S_WAIT;
            ec = (es == S_HI) ? inst[31:16] : ((es == S_LO) ? inst[15:0] : 16'h0);
            check_val($sformatf("state@%0d", k), 32'(dbg_state), 32'(es));
            check_val($sformatf("req@%0d", k), 32'(req), 32'(es == S_REQ));
            check_val($sformatf("ctrl@%0d", k), 32'(ctrl), 32'(ec));
            check_val($sformatf("rsp_valid@%0d", k), 32'(rsp_valid), 32'(k == d));
            check_val($sformatf("cmd_ready@%0d", k), 32'(cmd_ready), 32'(k > d));
            check_val($sformatf("busy@%0d", k), 32'(busy), 32'(k <= d));
        end
        cmd_valid = 1'b0;
    endtask

    // Reset lands in cycle at_k after acceptance; the command must vanish.
    task automatic run_abort(input logic [31:0] inst, input int rw, input int at_k, input state_e st);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_inst = inst; ready = 1'b0; stat = 2'b00;
        for (int k = 1; k <= at_k; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            ready     = (k == rw + 1);
            reset     = (k == at_k);
        end
        @(negedge clk);
        check_val("abort_pre_state", 32'(dbg_state), 32'(st));
        if (st == S_REQ) check_val("abort_pre_req", 32'(req), 32'(1));
        if (st == S_HI)  check_val("abort_pre_ctrl", 32'(ctrl), 32'(inst[31:16]));
        @(posedge clk); #1;
        reset = 1'b0; ready = 1'b0;
        pend_m = '0; data_prev = '0;
        @(negedge clk);
        check_val("abort_req", 32'(req), 32'(0));
        check_val("abort_ctrl", 32'(ctrl), 32'(0));
        check_val("abort_state", 32'(dbg_state), 32'(S_IDLE));
        check_val("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check_val("abort_busy", 32'(busy), 32'(0));
        repeat (4) @(posedge clk);
    endtask

    task automatic alarm_cycle(input logic [23:0] d, input logic [23:0] c);
        alarm_data = d; alarm_clr = c;
        pend_m    = (pend_m & ~c) | (d & ~data_prev);
        data_prev = d;
        @(posedge clk); #1;
        check_val("alarm_pend", 32'(alarm_pend), 32'(pend_m));
        check_val("alarm_irq", 32'(alarm_irq), 32'(pend_m != 0));
    endtask

    initial begin
        logic [2:0]  ops[6];
        logic [31:0] inst;
        ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

        do_reset();

        run_cmd(32'h2400_0005, 0, 2'b01, 0, 2'b00);   // set clock, ACK at N+5
        run_cmd(32'h7F00_0000, 0, 2'b01, 0, 2'b00);   // mode write, ACK at N+4
        run_cmd(32'h8000_0000, 0, 2'b00, 0, 2'b00);   // opcode 100 rejected
        run_cmd(32'h0000_1234, 0, 2'b00, 0, 2'b00);   // opcode 000 rejected
        run_cmd(32'h2400_0005, 20, 2'b01, 0, 2'b00);  // ready timeout
        run_cmd(32'h4000_0003, 15, 2'b01, 0, 2'b00);  // ready on last allowed cycle
        run_cmd(32'hA000_0001, 0, 2'b00, 40, 2'b00);  // stat timeout
        run_cmd(32'hC123_4567, 1, 2'b01, 31, 2'b01);  // stat on last WAIT cycle, early stat ignored
        run_cmd(32'h2400_0005, 0, 2'b11, 0, 2'b00);   // reserved stat -> NACK
        run_cmd(32'hE000_0007, 2, 2'b10, 3, 2'b11);   // Nack stat -> NACK

        for (int i = 0; i < 6; i++) begin
            inst = {ops[$urandom_range(0, 5)], 29'($urandom())};
            run_cmd(inst, int'($urandom_range(0, 4)), 2'($urandom_range(1, 3)),
                    int'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
        end

        run_abort(32'h2400_0005, 0, 2, S_HI);
        run_abort(32'h5A5A_1234, 20, 5, S_REQ);

        alarm_cycle(24'h000020, 24'h0);
        alarm_cycle(24'h000020, 24'h0);
        alarm_cycle(24'h000000, 24'h0);
        alarm_cycle(24'h000020, 24'h000020);   // new edge and clear together
        alarm_cycle(24'h000020, 24'h0);
        alarm_cycle(24'h000000, 24'h000020);   // clear alone
        alarm_cycle(24'h000000, 24'h0);

        // Alarm capture keeps running while a long command is in flight.
        fork
            run_cmd(32'h2222_3333, 1, 2'b00, 40, 2'b00);
            for (int i = 0; i < 30; i++) begin
                alarm_cycle(24'($urandom()), ($urandom_range(0, 3) == 0) ? 24'($urandom()) : 24'h0);
            end
        join
        alarm_cycle(24'h0, 24'hFFFFFF);

        repeat (3) @(posedge clk);
        check_val("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
